spi_slave: RTL
==============

SPI_SLAVE -- requirements
Module: spi_slave

Interface
REQ-001 SHALL have port clk  input  1  single system clock; all logic on its rising edge.
REQ-002 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-003 SHALL have port word  input  1  frame size select: 1 = 32-bit frame, 0 = 8-bit frame; sampled at frame start.
REQ-004 SHALL have port dataTx  input  32  response data for the next frame.
REQ-005 SHALL have port txLoad  input  1  one-cycle strobe writing dataTx into the tx shadow register.
REQ-006 SHALL have port txEmpty  output  1  high when the tx shadow holds no unsent data.
REQ-007 SHALL have port dataRx  output  32  last complete received frame; upper 24 bits zero in byte frames.
REQ-008 SHALL have port rxValid  output  1  one-cycle pulse when dataRx updates.
REQ-009 SHALL have port rxAck  input  1  strobe: consumer has read dataRx.
REQ-010 SHALL have port ovr  output  1  sticky overrun flag.
REQ-011 SHALL have port SS_n  input  1  active-low slave select from the master.
REQ-012 SHALL have port SCLK  input  1  serial clock from the master, idle low.
REQ-013 SHALL have port MOSI  input  1  serial data from the master.
REQ-014 SHALL have port MISO  output  1  serial data to the master.
REQ-015 SHALL have port MISO_oe  output  1  MISO drive enable, high only while SS_n is low.

Function
REQ-016 SHALL pass SS_n, SCLK and MOSI through 2-flop synchronizers and detect SCLK and SS_n edges on the synchronized values; SCLK frequency SHALL be at most clk/8.
REQ-017 SHALL use SPI mode 0: MOSI sampled on SCLK rising edge; MISO changed on SCLK falling edge.
REQ-018 SHALL implement states IDLE (SS_n high), LOAD (one cycle after SS_n fall), SHIFT (counting bits); IDLE->LOAD on SS_n fall, LOAD->SHIFT unconditionally, SHIFT->IDLE on SS_n rise.
REQ-019 SHALL in LOAD latch word, copy the tx shadow (or 0xFFFFFFFF if txEmpty) into the shift register, set txEmpty, and present the first bit on MISO.
REQ-020 SHALL transmit and receive bytes MSbit first; in word frames bytes SHALL go LSByte first (wire order bits 7..0, 15..8, 23..16, 31..24).
REQ-021 SHALL, on the 8th (byte) or 32nd (word) sampled rising edge, update dataRx and pulse rxValid exactly 1 cycle after that edge is detected, then reset the bit counter and reload as in REQ-019 for a back-to-back frame while SS_n stays low.
REQ-022 SHALL discard a partial frame when SS_n rises mid-frame: no rxValid, dataRx unchanged, tx shadow not restored.
REQ-023 SHALL keep MISO_oe low and MISO high in IDLE.
REQ-024 SHALL, on txLoad, write dataTx to the shadow and clear txEmpty; txLoad in the same cycle as a LOAD SHALL be taken by the next frame, the current frame using the prior shadow contents.
REQ-025 SHALL ignore SCLK edges while SS_n (synchronized) is high.

Reset
REQ-026 SHALL on rst low asynchronously force: state IDLE, bit counter 0, shift register 0xFFFFFFFF, dataRx 0, rxValid 0, txEmpty 1, ovr 0, MISO 1, MISO_oe 0.
REQ-027 SHALL, when reset asserts mid-frame, abandon the frame and resume only at the next SS_n fall after release.

Configuration
REQ-028 SHALL, with SPI_SLAVE_OVR_EN defined, track an unread flag (set by rxValid, cleared by rxAck) and set ovr when rxValid fires while unread is still set; ovr cleared only by reset; rxAck and a new rxValid in the same cycle SHALL leave unread set and not set ovr.
REQ-029 SHALL, without SPI_SLAVE_OVR_EN, tie ovr to 0 and ignore rxAck.

Verification
REQ-030 Byte frame: txLoad 0x000000A5, master sends 0x3C at clk/64 -> MISO bits 1010_0101, dataRx 0x0000003C, one rxValid pulse, txEmpty 1.
REQ-031 Word frame: word=1, txLoad 0x11223344, master sends 0xDEADBEEF at clk/8 -> wire MISO bytes 44,33,22,11; dataRx 0xDEADBEEF.
REQ-032 Empty shadow: no txLoad, byte frame 0x55 -> MISO 0xFF, dataRx 0x00000055.
REQ-033 Abort: SS_n rises after 5 bits of a byte frame -> no rxValid, dataRx unchanged, MISO_oe 0.
REQ-034 Overrun (SPI_SLAVE_OVR_EN): two back-to-back byte frames without rxAck -> ovr 1 after second rxValid; with rxAck between -> ovr 0.
REQ-035 Reset mid-frame: rst low after 3 bits -> all outputs at REQ-026 values; next full frame 0x81 received correctly.

Source files
------------

// File: rtl/spi_slave.sv
// SPI mode-0 slave with 8/32-bit frames, a tx shadow register and back-to-back framing.
// Optional overrun detection is compiled in with `define SPI_SLAVE_OVR_EN.
module spi_slave (
  input  logic        clk,
  input  logic        rst,
  input  logic        word,
  input  logic [31:0] dataTx,
  input  logic        txLoad,
  output logic        txEmpty,
  output logic [31:0] dataRx,
  output logic        rxValid,
  input  logic        rxAck,
  output logic        ovr,
  input  logic        SS_n,
  input  logic        SCLK,
  input  logic        MOSI,
  output logic        MISO,
  output logic        MISO_oe,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2
  } state_t;

  state_t      state, state_nxt;

  logic [1:0]  ss_sync, sclk_sync, mosi_sync;
  logic        ss_d, sclk_d;
  logic        ss_s, sclk_s, mosi_s;
  logic        ss_fall, sclk_rise, sclk_fall;

  logic [4:0]  bit_cnt;
  logic [4:0]  last_idx;
  logic [31:0] tx_sr, rx_sr, rx_next;
  logic [31:0] tx_shadow;
  logic        tx_empty;
  logic        word_q;
  logic [31:0] data_rx;
  logic        rx_valid;

  logic        load_frame, sample, shift_out, frame_done, reload;

  // Wire order is LSByte first, MSbit first within each byte; swapping bytes
  // lets both shift registers run plain MSB-first.
  function automatic logic [31:0] bswap(input logic [31:0] d);
    return {d[7:0], d[15:8], d[23:16], d[31:24]};
  endfunction

  // SS resets low in the synchronizer so that a select held low across reset
  // is not mistaken for a fresh falling edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ss_sync   <= 2'b00;
      sclk_sync <= 2'b00;
      mosi_sync <= 2'b00;
      ss_d      <= 1'b0;
      sclk_d    <= 1'b0;
    end else begin
      ss_sync   <= {ss_sync[0], SS_n};
      sclk_sync <= {sclk_sync[0], SCLK};
      mosi_sync <= {mosi_sync[0], MOSI};
      ss_d      <= ss_sync[1];
      sclk_d    <= sclk_sync[1];
    end
  end

  assign ss_s      = ss_sync[1];
  assign sclk_s    = sclk_sync[1];
  assign mosi_s    = mosi_sync[1];
  assign ss_fall   = ss_d & ~ss_s;
  assign sclk_rise = sclk_s & ~sclk_d;
  assign sclk_fall = ~sclk_s & sclk_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    load_frame = 1'b0;
    case (state)
      IDLE:    if (ss_fall) state_nxt = LOAD;
      LOAD: begin
        load_frame = 1'b1;
        state_nxt  = SHIFT;
      end
      SHIFT:   if (ss_s) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign last_idx   = word_q ? 5'd31 : 5'd7;
  assign sample     = (state == SHIFT) && !ss_s && sclk_rise;
  assign frame_done = sample && (bit_cnt == last_idx);
  // The falling edge that closes the last bit must not shift the freshly
  // reloaded register, hence no shifting while the counter sits at zero.
  assign shift_out  = (state == SHIFT) && !ss_s && sclk_fall && (bit_cnt != 5'd0);
  assign reload     = load_frame || frame_done;
  assign rx_next    = {rx_sr[30:0], mosi_s};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bit_cnt   <= 5'd0;
      tx_sr     <= 32'hFFFF_FFFF;
      rx_sr     <= 32'h0;
      word_q    <= 1'b0;
      data_rx   <= 32'h0;
      rx_valid  <= 1'b0;
      tx_shadow <= 32'h0;
      tx_empty  <= 1'b1;
    end else begin
      rx_valid <= frame_done;
      if (frame_done)
        data_rx <= word_q ? bswap(rx_next) : {24'h0, rx_next[7:0]};

      if (state == IDLE || reload) bit_cnt <= 5'd0;
      else if (sample)             bit_cnt <= bit_cnt + 5'd1;

      if (sample) rx_sr <= rx_next;

      if (reload) begin
        word_q <= word;
        tx_sr  <= tx_empty ? 32'hFFFF_FFFF : bswap(tx_shadow);
      end else if (shift_out) begin
        tx_sr  <= {tx_sr[30:0], 1'b1};
      end

      // A load coinciding with a reload lands in the shadow for the next frame.
      if (txLoad) begin
        tx_shadow <= dataTx;
        tx_empty  <= 1'b0;
      end else if (reload) begin
        tx_empty  <= 1'b1;
      end
    end
  end

`ifdef SPI_SLAVE_OVR_EN
  logic unread, ovr_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      unread <= 1'b0;
      ovr_q  <= 1'b0;
    end else if (rx_valid) begin
      unread <= 1'b1;
      if (unread && !rxAck) ovr_q <= 1'b1;
    end else if (rxAck) begin
      unread <= 1'b0;
    end
  end

  assign ovr = ovr_q;
`else
  logic unused_rx_ack;
  assign unused_rx_ack = rxAck;
  assign ovr           = 1'b0;
`endif

  assign txEmpty   = tx_empty;
  assign dataRx    = data_rx;
  assign rxValid   = rx_valid;
  assign MISO      = (state == IDLE) ? 1'b1 : tx_sr[31];
  assign MISO_oe   = (state != IDLE);
  assign dbg_state = state;

endmodule
